// File: rtl/psum_bus_pkg.sv
// Shared types and width helpers for the row-bus psum return path.
package psum_bus_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_COL    = 4;
  localparam int DEF_NUM_ROW    = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef logic [2*DEF_DATA_WIDTH-1:0] psum_t;

  function automatic int xid_width(input int num_col);
    return $clog2(num_col) + 1;
  endfunction

  function automatic int yid_width(input int num_row);
    return $clog2(num_row) + 1;
  endfunction

  // Width of a plain column index (0..num_col-1)
  function automatic int idx_width(input int num_col);
    return (num_col > 1) ? $clog2(num_col) : 1;
  endfunction

  localparam int DEF_XID_W = xid_width(DEF_NUM_COL);
  localparam int DEF_YID_W = yid_width(DEF_NUM_ROW);

endpackage

// File: rtl/xbus_psum_collector_if.sv
// PE-side psum inputs and global-buffer-side psum output of one PE row.
interface xbus_psum_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int NUM_ROW    = 4
);
  import psum_bus_pkg::*;

  localparam int PSW = 2 * DATA_WIDTH;
  localparam int XW  = xid_width(NUM_COL);
  localparam int YW  = yid_width(NUM_ROW);

  logic [NUM_COL*PSW-1:0] pe_psum_data;
  logic [NUM_COL-1:0]     pe_psum_valid;
  logic [NUM_COL-1:0]     pe_psum_ready;
  logic [PSW-1:0]         gb_psum_data;
  logic [XW-1:0]          gb_x_id;
  logic [YW-1:0]          gb_y_id;
  logic                   gb_psum_valid;
  logic                   gb_psum_ready;

  modport slave (
    input  pe_psum_data, pe_psum_valid, gb_psum_ready,
    output pe_psum_ready, gb_psum_data, gb_x_id, gb_y_id, gb_psum_valid
  );

  modport master (
    output pe_psum_data, pe_psum_valid, gb_psum_ready,
    input  pe_psum_ready, gb_psum_data, gb_x_id, gb_y_id, gb_psum_valid
  );

endinterface

// File: rtl/xbus_psum_collector_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]                          req,
  input  logic [psum_bus_pkg::idx_width(NUM_REQ)-1:0] ptr,
  output logic [psum_bus_pkg::idx_width(NUM_REQ)-1:0] grant,
  output logic                                        found
);
  import psum_bus_pkg::*;

  localparam int IW = idx_width(NUM_REQ);

  int            cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    grant    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand     = (int'(ptr) + off) % NUM_REQ;
      cand_idx = IW'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        grant = cand_idx;
      end
    end
  end

endmodule

// File: rtl/xbus_psum_collector.sv
// Row psum collector: per-column capture slots drained round-robin to the global buffer.
// Optional dropped-psum counter enabled by defining PSUM_DROP_CNT_EN.
module xbus_psum_collector #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int NUM_ROW    = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  output logic                   rst_busy,
  input  logic [$clog2(NUM_ROW):0] y_id,
  xbus_psum_if.slave             bus
`ifdef PSUM_DROP_CNT_EN
  ,
  output logic [15:0]            dropped_cnt
`endif
);
  import psum_bus_pkg::*;

  localparam int PSW = 2 * DATA_WIDTH;
  localparam int XW  = xid_width(NUM_COL);
  localparam int YW  = yid_width(NUM_ROW);
  localparam int IW  = idx_width(NUM_COL);

  state_e               state_q, state_d;
  logic [IW-1:0]        clr_cnt_q, clr_cnt_d;
  logic [NUM_COL-1:0]   slot_full_q, slot_full_d;
  logic [PSW-1:0]       slot_data_q [NUM_COL];
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 gb_valid_q, gb_valid_d;
  logic [PSW-1:0]       gb_data_q, gb_data_d;
  logic [XW-1:0]        gb_x_q, gb_x_d;
  logic [YW-1:0]        gb_y_q, gb_y_d;
  logic [YW-1:0]        y_id_q, y_id_d;

  logic                 run;
  logic                 load_en;
  logic [NUM_COL-1:0]   pe_ready;
  logic [NUM_COL-1:0]   pe_accept;
  logic [IW-1:0]        arb_grant;
  logic                 arb_found;

  assign run       = (state_q == RUN);
  assign pe_ready  = {NUM_COL{run & ~flush}} & ~slot_full_q;
  assign pe_accept = bus.pe_psum_valid & pe_ready;
  assign load_en   = run & ~flush & (~gb_valid_q | bus.gb_psum_ready);

  rr_arbiter #(
    .NUM_REQ (NUM_COL)
  ) u_arb (
    .req   (slot_full_q),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .found (arb_found)
  );

  always_comb begin : ctrl_comb
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        if (flush) begin
          clr_cnt_d = '0;
        end else if (clr_cnt_q == IW'(NUM_COL - 1)) begin
          state_d   = RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + IW'(1);
        end
      end
      RUN: begin
        if (flush) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_comb begin : data_comb
    slot_full_d = slot_full_q;
    rr_ptr_d    = rr_ptr_q;
    gb_valid_d  = gb_valid_q;
    gb_data_d   = gb_data_q;
    gb_x_d      = gb_x_q;
    gb_y_d      = gb_y_q;
    y_id_d      = run ? y_id : y_id_q;
    if (flush) begin
      // A handshake in this cycle still completes; everything else is discarded
      slot_full_d = '0;
      gb_valid_d  = 1'b0;
    end else if (!run) begin
      slot_full_d[clr_cnt_q] = 1'b0;
    end else begin
      if (load_en) begin
        if (arb_found) begin
          gb_valid_d             = 1'b1;
          gb_data_d              = slot_data_q[arb_grant];
          gb_x_d                 = XW'(arb_grant);
          gb_y_d                 = y_id_q;
          slot_full_d[arb_grant] = 1'b0;
          rr_ptr_d = (arb_grant == IW'(NUM_COL - 1)) ? '0 : arb_grant + IW'(1);
        end else begin
          gb_valid_d = 1'b0;
        end
      end
      // Refill after free so a slot drained and recaptured this cycle stays full
      slot_full_d = slot_full_d | pe_accept;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      slot_full_q <= '0;
      rr_ptr_q    <= '0;
      gb_valid_q  <= 1'b0;
      gb_data_q   <= '0;
      gb_x_q      <= '0;
      gb_y_q      <= '0;
      y_id_q      <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      slot_full_q <= slot_full_d;
      rr_ptr_q    <= rr_ptr_d;
      gb_valid_q  <= gb_valid_d;
      gb_data_q   <= gb_data_d;
      gb_x_q      <= gb_x_d;
      gb_y_q      <= gb_y_d;
      y_id_q      <= y_id_d;
    end
  end

  // Slot payloads need no reset: slot_full_q qualifies them
  for (genvar gi = 0; gi < NUM_COL; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (pe_accept[gi]) begin
        slot_data_q[gi] <= bus.pe_psum_data[gi*PSW +: PSW];
      end
    end
  end

  assign rst_busy          = (state_q == CLEAR);
  assign bus.pe_psum_ready = pe_ready;
  assign bus.gb_psum_valid = gb_valid_q;
  assign bus.gb_psum_data  = gb_data_q;
  assign bus.gb_x_id       = gb_x_q;
  assign bus.gb_y_id       = gb_y_q;

`ifdef PSUM_DROP_CNT_EN
  logic [15:0] dropped_q;
  logic [16:0] drop_add;
  logic [16:0] drop_sum;

  always_comb begin
    drop_add = 17'(gb_valid_q & ~bus.gb_psum_ready);
    for (int i = 0; i < NUM_COL; i++) begin
      drop_add = drop_add + 17'(slot_full_q[i]);
    end
    drop_sum = {1'b0, dropped_q} + drop_add;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dropped_q <= '0;
    end else if (flush) begin
      dropped_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign dropped_cnt = dropped_q;
`endif

endmodule

// File: tb/tb_xbus_psum_collector.sv
// Scoreboard bench for xbus_psum_collector: inputs driven and outputs sampled on the falling edge.
module tb_xbus_psum_collector;
  import psum_bus_pkg::*;

  localparam int DW  = 16;
  localparam int NC  = 4;
  localparam int NR  = 4;
  localparam int PSW = 2 * DW;
  localparam int XW  = xid_width(NC);
  localparam int YW  = yid_width(NR);

  typedef struct {
    psum_t         data;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } exp_t;

  exp_t sb_q[$];

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic          rst_busy;
  logic [YW-1:0] y_id = YW'(1);
`ifdef PSUM_DROP_CNT_EN
  logic [15:0]   dropped_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  xbus_psum_if #(.DATA_WIDTH(DW), .NUM_COL(NC), .NUM_ROW(NR)) bus ();

  xbus_psum_collector #(
    .DATA_WIDTH (DW),
    .NUM_COL    (NC),
    .NUM_ROW    (NR)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .rst_busy (rst_busy),
    .y_id     (y_id),
    .bus      (bus)
`ifdef PSUM_DROP_CNT_EN
    ,
    .dropped_cnt (dropped_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic set_col(input int i, input psum_t d);
    bus.pe_psum_data[i*PSW +: PSW] = d;
    bus.pe_psum_valid[i]           = 1'b1;
  endtask

  task automatic push_exp(input psum_t d, input int x, input int y);
    exp_t e;
    e.data = d;
    e.x    = XW'(x);
    e.y    = YW'(y);
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    int busy;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rst_busy !== 1'b1 || bus.pe_psum_ready !== 4'h0 || bus.gb_psum_valid !== 1'b0 ||
        bus.gb_psum_data !== '0 || bus.gb_x_id !== '0 || bus.gb_y_id !== '0) begin
      n_errors++;
      $display("FAIL reset_values: busy=%b ready=%b valid=%b data=%h x=%0d y=%0d, expected busy=1 ready=0000 valid=0 data=0 x=0 y=0",
               rst_busy, bus.pe_psum_ready, bus.gb_psum_valid, bus.gb_psum_data, bus.gb_x_id, bus.gb_y_id);
    end
`ifdef PSUM_DROP_CNT_EN
    n_checks++;
    if (dropped_cnt !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_dropped: got %0d expected 0", dropped_cnt);
    end
`endif
    rstn = 1'b1;
    busy = 0;
    for (int c = 0; c < 12; c++) begin
      if (!rst_busy) break;
      busy++;
      n_checks++;
      if (bus.pe_psum_ready !== 4'h0) begin
        n_errors++;
        $display("FAIL reset_ready_busy: got %b expected 0000", bus.pe_psum_ready);
      end
      @(negedge clk);
    end
    n_checks++;
    if (busy != 4) begin
      n_errors++;
      $display("FAIL reset_busy_len: got %0d cycles expected 4", busy);
    end
    n_checks++;
    if (bus.pe_psum_ready !== 4'hF) begin
      n_errors++;
      $display("FAIL reset_ready_run: got %b expected 1111", bus.pe_psum_ready);
    end
    $display("reset: busy for %0d cycles, ready=%b", busy, bus.pe_psum_ready);
  endtask

  task automatic test_back_to_back();
    exp_t  e;
    psum_t d;
    int    first, last;
    for (int b = 0; b < 2; b++) begin
      y_id = YW'(b + 1);
      @(negedge clk);
      @(negedge clk);
      bus.gb_psum_ready = 1'b1;
      n_checks++;
      if (bus.pe_psum_ready !== 4'hF) begin
        n_errors++;
        $display("FAIL burst_ready: got %b expected 1111", bus.pe_psum_ready);
      end
      for (int i = 0; i < NC; i++) begin
        d = psum_t'(32'hB000_0000 + b * 256 + i);
        set_col(i, d);
        push_exp(d, i, b + 1);
      end
      @(negedge clk);
      bus.pe_psum_valid = '0;
      first = -1;
      last  = -1;
      for (int c = 0; c < 12 && sb_q.size() > 0; c++) begin
        if (bus.gb_psum_valid && bus.gb_psum_ready) begin
          e = sb_q.pop_front();
          n_checks++;
          if (bus.gb_psum_data !== e.data || bus.gb_x_id !== e.x || bus.gb_y_id !== e.y) begin
            n_errors++;
            $display("FAIL burst_out: got data=%h x=%0d y=%0d expected data=%h x=%0d y=%0d",
                     bus.gb_psum_data, bus.gb_x_id, bus.gb_y_id, e.data, e.x, e.y);
          end
          $display("burst %0d: out data=%h x=%0d y=%0d", b, bus.gb_psum_data, bus.gb_x_id, bus.gb_y_id);
          if (first < 0) first = c;
          last = c;
        end
        @(negedge clk);
      end
      n_checks++;
      if (sb_q.size() != 0 || last - first != NC - 1) begin
        n_errors++;
        $display("FAIL burst_timing: left=%0d span=%0d expected left=0 span=%0d", sb_q.size(), last - first, NC - 1);
      end
      sb_q.delete();
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   first, last;
    psum_t d1a = 32'h1111_0001;
    psum_t d3  = 32'h3333_0003;
    psum_t d1b = 32'h1111_0002;
    bus.gb_psum_ready = 1'b0;
    set_col(1, d1a);
    set_col(3, d3);
    push_exp(d1a, 1, 2);
    push_exp(d3, 3, 2);
    push_exp(d1b, 1, 2);
    @(negedge clk);
    bus.pe_psum_valid = '0;
    @(negedge clk);
    n_checks++;
    if (bus.gb_psum_valid !== 1'b1 || bus.gb_x_id !== XW'(1) || bus.pe_psum_ready[1] !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_first_load: valid=%b x=%0d ready1=%b expected valid=1 x=1 ready1=1",
               bus.gb_psum_valid, bus.gb_x_id, bus.pe_psum_ready[1]);
    end
    set_col(1, d1b);
    @(negedge clk);
    bus.pe_psum_valid = '0;
    for (int h = 0; h < 5; h++) begin
      n_checks++;
      if (bus.gb_psum_valid !== 1'b1 || bus.gb_psum_data !== d1a || bus.gb_x_id !== XW'(1) ||
          bus.pe_psum_ready[1] !== 1'b0 || bus.pe_psum_ready[3] !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_hold: valid=%b data=%h x=%0d ready=%b expected valid=1 data=%h x=1 ready=x0x0",
                 bus.gb_psum_valid, bus.gb_psum_data, bus.gb_x_id, bus.pe_psum_ready, d1a);
      end
      $display("backpressure hold %0d: data=%h x=%0d ready=%b", h, bus.gb_psum_data, bus.gb_x_id, bus.pe_psum_ready);
      @(negedge clk);
    end
    bus.gb_psum_ready = 1'b1;
    first = -1;
    last  = -1;
    for (int c = 0; c < 12 && sb_q.size() > 0; c++) begin
      if (bus.gb_psum_valid && bus.gb_psum_ready) begin
        e = sb_q.pop_front();
        n_checks++;
        if (bus.gb_psum_data !== e.data || bus.gb_x_id !== e.x || bus.gb_y_id !== e.y) begin
          n_errors++;
          $display("FAIL bp_out: got data=%h x=%0d y=%0d expected data=%h x=%0d y=%0d",
                   bus.gb_psum_data, bus.gb_x_id, bus.gb_y_id, e.data, e.x, e.y);
        end
        $display("backpressure: out data=%h x=%0d", bus.gb_psum_data, bus.gb_x_id);
        if (first < 0) first = c;
        last = c;
      end
      @(negedge clk);
    end
    n_checks++;
    if (sb_q.size() != 0 || last - first != 2) begin
      n_errors++;
      $display("FAIL bp_drain: left=%0d span=%0d expected left=0 span=2", sb_q.size(), last - first);
    end
    sb_q.delete();
  endtask

  task automatic test_single();
    exp_t e;
    y_id = YW'(1);
    @(negedge clk);
    @(negedge clk);
    bus.gb_psum_ready = 1'b1;
    n_checks++;
    if (bus.pe_psum_ready[2] !== 1'b1) begin
      n_errors++;
      $display("FAIL single_ready: got %b expected 1", bus.pe_psum_ready[2]);
    end
    set_col(2, 32'h0000_1234);
    push_exp(32'h0000_1234, 2, 1);
    @(negedge clk);
    bus.pe_psum_valid = '0;
    n_checks++;
    if (bus.gb_psum_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL single_early: valid=%b expected 0 one cycle after capture", bus.gb_psum_valid);
    end
    @(negedge clk);
    n_checks++;
    if (bus.gb_psum_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL single_latency: valid=%b expected 1", bus.gb_psum_valid);
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if (bus.gb_psum_data !== e.data || bus.gb_x_id !== e.x || bus.gb_y_id !== e.y) begin
        n_errors++;
        $display("FAIL single_out: got data=%h x=%0d y=%0d expected data=%h x=%0d y=%0d",
                 bus.gb_psum_data, bus.gb_x_id, bus.gb_y_id, e.data, e.x, e.y);
      end
    end
    $display("single: out data=%h x=%0d y=%0d", bus.gb_psum_data, bus.gb_x_id, bus.gb_y_id);
    @(negedge clk);
    n_checks++;
    if (bus.gb_psum_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL single_extra: valid=%b expected 0", bus.gb_psum_valid);
    end
    sb_q.delete();
  endtask

  task automatic test_flush();
    int busy;
    bus.gb_psum_ready = 1'b0;
    for (int i = 0; i < NC; i++) set_col(i, psum_t'(32'hF000_0000 + i));
    @(negedge clk);
    bus.pe_psum_valid = '0;
    @(negedge clk);
    n_checks++;
    if (bus.gb_psum_valid !== 1'b1 || bus.gb_x_id !== XW'(3)) begin
      n_errors++;
      $display("FAIL flush_setup: valid=%b x=%0d expected valid=1 x=3", bus.gb_psum_valid, bus.gb_x_id);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (bus.gb_psum_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_valid: got %b expected 0", bus.gb_psum_valid);
    end
    busy = 0;
    for (int c = 0; c < 12; c++) begin
      if (!rst_busy) break;
      busy++;
      @(negedge clk);
    end
    n_checks++;
    if (busy != 4 || bus.pe_psum_ready !== 4'hF) begin
      n_errors++;
      $display("FAIL flush_busy: busy=%0d ready=%b expected busy=4 ready=1111", busy, bus.pe_psum_ready);
    end
`ifdef PSUM_DROP_CNT_EN
    n_checks++;
    if (dropped_cnt !== 16'd4) begin
      n_errors++;
      $display("FAIL flush_dropped: got %0d expected 4", dropped_cnt);
    end
`endif
    bus.gb_psum_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      n_checks++;
      if (bus.gb_psum_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL flush_stale: valid=%b data=%h x=%0d expected valid=0", bus.gb_psum_valid, bus.gb_psum_data, bus.gb_x_id);
      end
      @(negedge clk);
    end
    $display("flush: busy %0d cycles, no stale output", busy);
  endtask

  task automatic test_flush_same_cycle();
    exp_t e;
    int   busy;
    bus.gb_psum_ready = 1'b1;
    set_col(0, 32'h0000_00A0);
    set_col(1, 32'h0000_00A1);
    push_exp(32'h0000_00A0, 0, 1);
    @(negedge clk);
    bus.pe_psum_valid = '0;
    @(negedge clk);
    n_checks++;
    if (bus.gb_psum_valid !== 1'b1 || sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL fhs_valid: valid=%b expected 1", bus.gb_psum_valid);
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if (bus.gb_psum_data !== e.data || bus.gb_x_id !== e.x || bus.gb_y_id !== e.y) begin
        n_errors++;
        $display("FAIL fhs_out: got data=%h x=%0d y=%0d expected data=%h x=%0d y=%0d",
                 bus.gb_psum_data, bus.gb_x_id, bus.gb_y_id, e.data, e.x, e.y);
      end
    end
    $display("flush+handshake: delivered data=%h x=%0d", bus.gb_psum_data, bus.gb_x_id);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (bus.gb_psum_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL fhs_valid_after: got %b expected 0", bus.gb_psum_valid);
    end
    busy = 0;
    for (int c = 0; c < 12; c++) begin
      if (!rst_busy) break;
      busy++;
      @(negedge clk);
    end
    for (int c = 0; c < 8; c++) begin
      n_checks++;
      if (bus.gb_psum_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL fhs_stale: valid=%b data=%h x=%0d expected valid=0", bus.gb_psum_valid, bus.gb_psum_data, bus.gb_x_id);
      end
      @(negedge clk);
    end
`ifdef PSUM_DROP_CNT_EN
    n_checks++;
    if (dropped_cnt !== 16'd5) begin
      n_errors++;
      $display("FAIL fhs_dropped: got %0d expected 5", dropped_cnt);
    end
`endif
    sb_q.delete();
  endtask

  task automatic test_async_reset();
    int busy;
    bus.gb_psum_ready = 1'b0;
    set_col(2, 32'hCAFE_0002);
    @(negedge clk);
    bus.pe_psum_valid = '0;
    @(negedge clk);
    n_checks++;
    if (bus.gb_psum_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL async_setup: valid=%b expected 1", bus.gb_psum_valid);
    end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (rst_busy !== 1'b1 || bus.pe_psum_ready !== 4'h0 || bus.gb_psum_valid !== 1'b0 ||
        bus.gb_psum_data !== '0 || bus.gb_x_id !== '0 || bus.gb_y_id !== '0) begin
      n_errors++;
      $display("FAIL async_reset: busy=%b ready=%b valid=%b data=%h x=%0d y=%0d expected reset values",
               rst_busy, bus.pe_psum_ready, bus.gb_psum_valid, bus.gb_psum_data, bus.gb_x_id, bus.gb_y_id);
    end
`ifdef PSUM_DROP_CNT_EN
    n_checks++;
    if (dropped_cnt !== 16'd0) begin
      n_errors++;
      $display("FAIL async_dropped: got %0d expected 0", dropped_cnt);
    end
`endif
    @(negedge clk);
    rstn = 1'b1;
    busy = 0;
    for (int c = 0; c < 12; c++) begin
      if (!rst_busy) break;
      busy++;
      @(negedge clk);
    end
    n_checks++;
    if (busy != 4 || bus.gb_psum_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL async_recover: busy=%0d valid=%b expected busy=4 valid=0", busy, bus.gb_psum_valid);
    end
    $display("async reset: outputs cleared, busy %0d cycles after release", busy);
  endtask

  initial begin
    bus.pe_psum_data  = '0;
    bus.pe_psum_valid = '0;
    bus.gb_psum_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_single();
    test_flush();
    test_flush_same_cycle();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
